// File: rtl/xorshift_stream_if.sv
// Stream, reseed and (optional) backoff signals of xorshift_stream.
// master = the generator, slave = the consumer.
// XORSHIFT_BACKOFF_EN adds the bo_* signals.
interface xorshift_stream_if #(
  parameter int unsigned WIDTH = 32
);
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
`ifdef XORSHIFT_BACKOFF_EN
  logic             bo_req;
  logic [4:0]       bo_attempt;
  logic             bo_valid;
  logic [9:0]       bo_slots;
`endif

  modport master (
    input  seed_load, seed, rd_ready,
    output rd_valid, rd_data
`ifdef XORSHIFT_BACKOFF_EN
    ,
    input  bo_req, bo_attempt,
    output bo_valid, bo_slots
`endif
  );

  modport slave (
    output seed_load, seed, rd_ready,
    input  rd_valid, rd_data
`ifdef XORSHIFT_BACKOFF_EN
    ,
    output bo_req, bo_attempt,
    input  bo_valid, bo_slots
`endif
  );
endinterface

// File: rtl/xorshift_stream.sv
// xorshift_stream: 32/64-bit xorshift PRNG with a valid/ready output stream,
// runtime reseed and zero-seed protection. The state advances only when a
// word is consumed (or primed), so sequences are reproducible.
// Optional Ethernet backoff slot generator: define XORSHIFT_BACKOFF_EN.
module xorshift_stream #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] DEFAULT_SEED =
    WIDTH'((WIDTH == 32) ? 64'd2463534242 : 64'd88172645463325252)
) (
  input  logic               clk,
  input  logic               arst_n,
  xorshift_stream_if.master  s
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("xorshift_stream: WIDTH must be 32 or 64");
  end

  typedef enum logic {PRIME, READY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             adv;

  function automatic logic [WIDTH-1:0] xs_next(input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] t;
    t = y ^ (y << 13);
    if (WIDTH == 32) begin
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
    end else begin
      t = t ^ (t >> 7);
      t = t ^ (t << 17);
    end
    return t;
  endfunction

`ifdef XORSHIFT_BACKOFF_EN
  logic       bo_valid_q, bo_valid_d;
  logic [9:0] bo_slots_q, bo_slots_d;
  logic [4:0] bo_k;
  logic [9:0] bo_mask;

  // Slot count: top 10 bits of the pre-edge state, kept to min(attempt,10) LSBs.
  always_comb begin
    bo_k       = (s.bo_attempt > 5'd10) ? 5'd10 : s.bo_attempt;
    bo_mask    = 10'((11'd1 << bo_k) - 11'd1);
    bo_valid_d = s.bo_req;
    bo_slots_d = bo_slots_q;
    if (s.bo_req) begin
      bo_slots_d = y_q[WIDTH-1 -: 10] & bo_mask;
    end
  end
`endif

  // Next-state: reseed has priority; priming, a handshake and a backoff
  // request all share one state advance per edge.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    rd_data_d = rd_data_q;
    adv       = 1'b0;
    if (s.seed_load) begin
      y_d     = (s.seed == '0) ? DEFAULT_SEED : s.seed;
      state_d = PRIME;
    end else begin
      if (state_q == PRIME) begin
        rd_data_d = y_q;
        state_d   = READY;
        adv       = 1'b1;
      end else if (s.rd_ready) begin
        rd_data_d = y_q;
        adv       = 1'b1;
      end
`ifdef XORSHIFT_BACKOFF_EN
      if (s.bo_req) begin
        adv = 1'b1;
      end
`endif
      if (adv) begin
        y_d = xs_next(y_q);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= PRIME;
      y_q        <= DEFAULT_SEED;
      rd_data_q  <= '0;
`ifdef XORSHIFT_BACKOFF_EN
      bo_valid_q <= 1'b0;
      bo_slots_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      rd_data_q  <= rd_data_d;
`ifdef XORSHIFT_BACKOFF_EN
      bo_valid_q <= bo_valid_d;
      bo_slots_q <= bo_slots_d;
`endif
    end
  end

  assign s.rd_valid = (state_q == READY);
  assign s.rd_data  = rd_data_q;
`ifdef XORSHIFT_BACKOFF_EN
  assign s.bo_valid = bo_valid_q;
  assign s.bo_slots = bo_slots_q;
`endif

endmodule

// File: tb/tb_xorshift_stream.sv
// Self-checking bench for xorshift_stream: golden constants, a seed table,
// hand sequences for stall/reseed/reset, and random traffic against a model.
module tb_xorshift_stream;

  localparam longint unsigned DEF32 = 64'd2463534242;
  localparam longint unsigned DEF64 = 64'd88172645463325252;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  xorshift_stream_if #(.WIDTH(32)) if32 ();
  xorshift_stream_if #(.WIDTH(64)) if64 ();

  xorshift_stream #(.WIDTH(32)) u_dut32 (.clk(clk), .arst_n(arst_n), .s(if32));
  xorshift_stream #(.WIDTH(64)) u_dut64 (.clk(clk), .arst_n(arst_n), .s(if64));

  int checks = 0;
  int errors = 0;

  // Behavioural model of the 32-bit stream.
  longint unsigned m_y, m_data;
  logic            m_valid;
  logic            m_bo_valid;
  longint unsigned m_bo_slots;

  function automatic longint unsigned mnext(input longint unsigned y, input int w);
    longint unsigned msk, t;
    msk = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    t = (y ^ (y << 13)) & msk;
    if (w == 32) begin
      t = t ^ (t >> 17);
      t = (t ^ (t << 5)) & msk;
    end else begin
      t = t ^ (t >> 7);
      t = t ^ (t << 17);
    end
    return t & msk;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit hs, adv;
    longint unsigned y0;
    int unsigned k, a;
    y0 = m_y;
    if (!arst_n) begin
      m_y = DEF32; m_valid = 0; m_data = 0; m_bo_valid = 0; m_bo_slots = 0;
      return;
    end
    hs  = m_valid && if32.rd_ready;
    adv = 0;
`ifdef XORSHIFT_BACKOFF_EN
    m_bo_valid = if32.bo_req;
    if (if32.bo_req) begin
      a = if32.bo_attempt;
      k = (a > 10) ? 10 : a;
      m_bo_slots = (y0 >> 22) % (64'd1 << k);
      adv = 1;
    end
`endif
    if (if32.seed_load) begin
      m_y = (if32.seed == 0) ? DEF32 : longint'(if32.seed);
      m_valid = 0;
    end else begin
      if (!m_valid || hs) begin
        m_data  = y0;
        m_valid = 1;
        adv = 1;
      end
      if (adv) m_y = mnext(y0, 32);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_valid"}, longint'(if32.rd_valid), longint'(m_valid));
    chk({tag, "_data"}, longint'(if32.rd_data), m_data);
`ifdef XORSHIFT_BACKOFF_EN
    chk({tag, "_bo_valid"}, longint'(if32.bo_valid), longint'(m_bo_valid));
    chk({tag, "_bo_slots"}, longint'(if32.bo_slots), m_bo_slots);
`endif
  endtask

  typedef struct {
    logic [31:0]     seed;
    longint unsigned w0;
    longint unsigned w1;
  } vec_t;

  vec_t tbl[3];

  initial begin
    longint unsigned held;
    tbl[0] = '{32'd0,          64'd2463534242, 64'd723471715};
    tbl[1] = '{32'd1,          64'd1,          64'd270369};
    tbl[2] = '{32'd2463534242, 64'd2463534242, 64'd723471715};

    arst_n = 0;
    if32.seed_load = 0; if32.seed = '0; if32.rd_ready = 1;
    if64.seed_load = 0; if64.seed = '0; if64.rd_ready = 1;
`ifdef XORSHIFT_BACKOFF_EN
    if32.bo_req = 0; if32.bo_attempt = '0;
    if64.bo_req = 0; if64.bo_attempt = '0;
`endif
    step(); step();
    chk("rst_valid32", longint'(if32.rd_valid), 0);
    chk("rst_data32", longint'(if32.rd_data), 0);
    chk("rst_valid64", longint'(if64.rd_valid), 0);
    chk("rst_data64", longint'(if64.rd_data), 0);
    cmp_model("rst");

    // Golden start of both streams.
    arst_n = 1;
    step();
    chk("w0_valid32", longint'(if32.rd_valid), 1);
    chk("w0_data32", longint'(if32.rd_data), DEF32);
    chk("w0_valid64", longint'(if64.rd_valid), 1);
    chk("w0_data64", longint'(if64.rd_data), DEF64);
    step();
    chk("w1_data32", longint'(if32.rd_data), 64'd723471715);
    chk("w1_data64", longint'(if64.rd_data), 64'd8748534153485358512);
    cmp_model("w1");
    step(); cmp_model("w2");

    // Stall: output held for 5 cycles, then resumes without skipping.
    if32.rd_ready = 0;
    held = m_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", longint'(if32.rd_valid), 1);
      chk("stall_data", longint'(if32.rd_data), held);
    end
    if32.rd_ready = 1;
    step();
    cmp_model("resume");

    // Seed table: reseed, one bubble cycle, then the first two words.
    foreach (tbl[i]) begin
      if32.seed_load = 1; if32.seed = tbl[i].seed;
      step();
      if32.seed_load = 0;
      chk($sformatf("tbl%0d_bubble", i), longint'(if32.rd_valid), 0);
      step();
      chk($sformatf("tbl%0d_valid", i), longint'(if32.rd_valid), 1);
      chk($sformatf("tbl%0d_w0", i), longint'(if32.rd_data), tbl[i].w0);
      step();
      chk($sformatf("tbl%0d_w1", i), longint'(if32.rd_data), tbl[i].w1);
      cmp_model($sformatf("tbl%0d", i));
    end

    // Reseed coinciding with a handshake: old word stays, new stream follows.
    held = m_data;
    if32.rd_ready = 1; if32.seed_load = 1; if32.seed = 32'd1;
    step();
    if32.seed_load = 0;
    chk("ldhs_valid", longint'(if32.rd_valid), 0);
    chk("ldhs_data", longint'(if32.rd_data), held);
    step();
    chk("ldhs_w0", longint'(if32.rd_data), 1);
    step();
    chk("ldhs_w1", longint'(if32.rd_data), 64'd270369);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if32.rd_ready  = ($urandom % 4) != 0;
      if32.seed_load = ($urandom % 32) == 0;
      if32.seed      = (($urandom % 4) == 0) ? 32'd0 : 32'($urandom);
`ifdef XORSHIFT_BACKOFF_EN
      if32.bo_req     = ($urandom % 3) == 0;
      if32.bo_attempt = 5'($urandom_range(0, 16));
`endif
      step();
      cmp_model("rand");
    end
    if32.seed_load = 0;
`ifdef XORSHIFT_BACKOFF_EN
    if32.bo_req = 0;
`endif

    // Reset mid-stream overrides a simultaneous reseed and handshake.
    if32.rd_ready = 1; if32.seed_load = 1; if32.seed = 32'd5;
    arst_n = 0;
    step();
    if32.seed_load = 0;
    chk("mrst_valid", longint'(if32.rd_valid), 0);
    chk("mrst_data", longint'(if32.rd_data), 0);
    arst_n = 1;
    step();
    chk("mrst_w0", longint'(if32.rd_data), DEF32);
    step();
    chk("mrst_w1", longint'(if32.rd_data), 64'd723471715);
    cmp_model("mrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
